// File: rtl/letc_core_pkg.sv
// ============================================================================
// Package : letc_core_pkg
// Shared memory-op, access-size, AMO-op and Memory-2 RMW state encodings.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package letc_core_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_AMO   = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_e;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_AND  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8
    } amo_op_e;

    typedef enum logic [1:0] {
        M2_IDLE   = 2'd0,
        M2_AMO_WR = 2'd1,
        M2_DONE   = 2'd2
    } m2_rmw_state_e;

endpackage : letc_core_pkg

`default_nettype wire

// File: rtl/letc_core_amo_alu.sv
// ============================================================================
// Module : letc_core_amo_alu
// Combinational AMO ALU; word mode computes on bits [31:0] and replicates.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module letc_core_amo_alu
    import letc_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    logic            lt_s;
    logic            lt_u;

    // Sign-extending both word operands keeps signed and unsigned ordering
    // identical to true 32-bit comparisons, so one comparator serves both.
    always_comb begin
        a     = word_i ? XLEN'($signed(a_i[31:0])) : a_i;
        b     = word_i ? XLEN'($signed(b_i[31:0])) : b_i;
        lt_s  = $signed(a) < $signed(b);
        lt_u  = a < b;
        r     = b;
        case (op_i)
            AMO_ADD:  r = a + b;
            AMO_AND:  r = a & b;
            AMO_OR:   r = a | b;
            AMO_XOR:  r = a ^ b;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MINU: r = lt_u ? a : b;
            AMO_MAXU: r = lt_u ? b : a;
            default:  r = b;
        endcase
        res_o = word_i ? {(XLEN/32){r[31:0]}} : r;
    end

endmodule : letc_core_amo_alu

`default_nettype wire

// File: rtl/letc_core_stage_memory2_rmw.sv
// ============================================================================
// Module : letc_core_stage_memory2_rmw
// Memory-2 stage: load formatting and AMO read-modify-write sequencing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module letc_core_stage_memory2_rmw
    import letc_core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit AMO_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            ready_o,
    input  logic            in_valid_i,
    input  logic [1:0]      in_op_i,
    input  logic [1:0]      in_size_i,
    input  logic            in_signed_i,
    input  logic [3:0]      in_amo_op_i,
    input  logic [XLEN-1:0] in_addr_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [4:0]      in_rd_idx_i,
    input  logic            in_rd_we_i,
    input  logic            fwd_use_i,
    input  logic [XLEN-1:0] fwd_val_i,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    output logic            wr_valid_o,
    input  logic            wr_ready_i,
    output logic [XLEN-1:0] wr_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [1:0]      wr_size_o,
    output logic            out_valid_o,
    output logic [4:0]      out_rd_idx_o,
    output logic            out_rd_we_o,
    output logic [XLEN-1:0] out_rd_val_o
);

    localparam int OFFW = $clog2(XLEN / 8);

    m2_rmw_state_e   state_q, state_d;
    logic            valid_q;
    mem_op_e         op_q;
    mem_size_e       size_q;
    logic            signed_q;
    logic [3:0]      amo_op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      rd_idx_q;
    logic            rd_we_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] rdata_q;
    logic            wr_valid_q, wr_valid_d;

    logic            is_load;
    logic            is_amo;
    logic            amo_word;
    logic            word_hi;
    logic [XLEN-1:0] rs2_eff;
    logic [XLEN-1:0] old_lane;
    logic [XLEN-1:0] amo_rd;
    logic [XLEN-1:0] amo_res;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_fmt;
    logic            cap_old;
    logic            cap_rdata;

    // With the AMO path removed, AMO ops fall through to the load path.
    assign is_load  = (op_q == MEM_LOAD) || (!AMO_EN && (op_q == MEM_AMO));
    assign is_amo   = AMO_EN && (op_q == MEM_AMO);
    assign amo_word = (XLEN == 32) || (size_q != SIZE_DOUBLE);
    assign word_hi  = (XLEN == 64) && amo_word && addr_q[2];
    assign rs2_eff  = fwd_use_i ? fwd_val_i : rs2_q;
    assign old_lane = old_q >> {word_hi, 5'b00000};
    assign amo_rd   = amo_word ? XLEN'($signed(old_lane[31:0])) : old_q;

    letc_core_amo_alu #(
        .XLEN (XLEN)
    ) u_amo_alu (
        .op_i   (amo_op_q),
        .word_i (amo_word),
        .a_i    (old_lane),
        .b_i    (rs2_eff),
        .res_o  (amo_res)
    );

    always_comb begin
        shifted  = rsp_data_i >> {addr_q[OFFW-1:0], 3'b000};
        load_fmt = shifted;
        case (size_q)
            SIZE_BYTE: load_fmt = signed_q ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
            SIZE_HALF: load_fmt = signed_q ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
            SIZE_WORD: load_fmt = signed_q ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
            default:   load_fmt = shifted;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        case (state_q)
            M2_IDLE: begin
                if (valid_q) begin
                    if (is_load)     ready_o = rsp_valid_i;
                    else if (is_amo) ready_o = 1'b0;
                    else             ready_o = 1'b1;
                end
            end
            M2_DONE: ready_o = valid_q;
            default: ready_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_valid_d = wr_valid_q;
        cap_old    = 1'b0;
        cap_rdata  = 1'b0;
        if (flush_i) begin
            state_d    = M2_IDLE;
            wr_valid_d = 1'b0;
        end else begin
            case (state_q)
                M2_IDLE: begin
                    if (valid_q && rsp_valid_i) begin
                        if (is_amo) begin
                            state_d    = M2_AMO_WR;
                            wr_valid_d = 1'b1;
                            cap_old    = 1'b1;
                        end else if (is_load && stall_i) begin
                            state_d   = M2_DONE;
                            cap_rdata = 1'b1;
                        end
                    end
                end
                M2_AMO_WR: begin
                    if (wr_ready_i) begin
                        state_d    = M2_DONE;
                        wr_valid_d = 1'b0;
                    end
                end
                M2_DONE: begin
                    if (!stall_i) state_d = M2_IDLE;
                end
                default: state_d = M2_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= M2_IDLE;
            wr_valid_q <= 1'b0;
            old_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            if (cap_old)   old_q   <= rsp_data_i;
            if (cap_rdata) rdata_q <= load_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            op_q     <= MEM_NOP;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            amo_op_q <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            rd_idx_q <= '0;
            rd_we_q  <= 1'b0;
        end else begin
            if (flush_i)       valid_q <= 1'b0;
            else if (!stall_i) valid_q <= in_valid_i;
            if (!stall_i) begin
                op_q     <= mem_op_e'(in_op_i);
                size_q   <= mem_size_e'(in_size_i);
                signed_q <= in_signed_i;
                amo_op_q <= in_amo_op_i;
                addr_q   <= in_addr_i;
                rs2_q    <= in_rs2_i;
                rd_idx_q <= in_rd_idx_i;
                rd_we_q  <= in_rd_we_i;
            end else if (fwd_use_i) begin
                // A late forward must survive until the stall releases.
                rs2_q <= fwd_val_i;
            end
        end
    end

    always_comb begin
        out_rd_val_o = addr_q;
        if (is_amo)       out_rd_val_o = amo_rd;
        else if (is_load) out_rd_val_o = (state_q == M2_DONE) ? rdata_q : load_fmt;
    end

    assign out_valid_o  = valid_q && ready_o && !stall_i && !flush_i;
    assign out_rd_idx_o = rd_idx_q;
    assign out_rd_we_o  = valid_q && rd_we_q;
    assign wr_valid_o   = wr_valid_q;
    assign wr_addr_o    = addr_q;
    assign wr_size_o    = size_q;
    assign wr_data_o    = amo_res;

`ifndef SYNTHESIS
    a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_i |-> (valid_q && (is_load || is_amo) && (state_q == M2_IDLE)));
    a_no_in_when_held: assert property (@(posedge clk) disable iff (!rst_n)
        (stall_i || flush_i) |-> !in_valid_i);
    a_no_flush_amo_wr: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == M2_AMO_WR) |-> !flush_i);
    a_wr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_valid_o && !wr_ready_i) |=> wr_valid_o);
`endif

endmodule : letc_core_stage_memory2_rmw

`default_nettype wire
